// File: rtl/lane_sched.sv
// lane_sched: five-lane road scheduler moving ten cars on a 0..20 grid.
// Per-lane period counters raise requests; a round-robin FSM steps the
// two cars of the granted lane, one car per cycle.
// Ports:
//   i_Clk        clock, all logic on the rising edge
//   i_Rst        synchronous active-high reset
//   i_Freeze     hold counters and grants (an update in flight completes)
//   i_Level_Up   pulse: raise level (saturating at 7), restart counters
//   o_Car_X      10 x 6-bit car X positions, car i at [i*6 +: 6]
//   o_Car_Y      10 x 6-bit constant car lanes, same packing
//   o_Level      current level 0..7
//   o_Busy       high in UPD_A / UPD_B
//   o_Overrun    sticky: a lane ticked while its request was pending
module lane_sched #(
  parameter int unsigned c_BASE_PERIOD = 700000,
  parameter int unsigned c_PERIOD_STEP = 100000,
  parameter int unsigned c_MIN_PERIOD  = 100000,
  parameter int unsigned c_LANE_SKEW   = 50000,
  parameter int          COUNTER_WIDTH = 21
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Freeze,
  input  logic        i_Level_Up,
  output logic [59:0] o_Car_X,
  output logic [59:0] o_Car_Y,
  output logic [2:0]  o_Level,
  output logic        o_Busy,
  output logic        o_Overrun
);

  typedef enum logic [1:0] {IDLE, UPD_A, UPD_B} state_t;

  function automatic logic [3:0] car_a(input logic [2:0] lane);
    case (lane)
      3'd0:    return 4'd0;
      3'd1:    return 4'd1;
      3'd2:    return 4'd4;
      3'd3:    return 4'd5;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] car_b(input logic [2:0] lane);
    case (lane)
      3'd0:    return 4'd2;
      3'd1:    return 4'd3;
      3'd2:    return 4'd6;
      3'd3:    return 4'd7;
      default: return 4'd9;
    endcase
  endfunction

  function automatic logic [4:0] init_x(input int i);
    case (i)
      0:       return 5'd0;
      1:       return 5'd20;
      2:       return 5'd6;
      3:       return 5'd14;
      4:       return 5'd3;
      5:       return 5'd4;
      6:       return 5'd9;
      7:       return 5'd18;
      8:       return 5'd4;
      default: return 5'd11;
    endcase
  endfunction

  function automatic logic [5:0] car_y(input int i);
    case (i)
      0, 2:    return 6'd12;
      1, 3:    return 6'd11;
      4, 6:    return 6'd10;
      5, 7:    return 6'd9;
      default: return 6'd8;
    endcase
  endfunction

  // Even lanes drive right, odd lanes left; both wrap across 0..20.
  function automatic logic [4:0] move(input logic [4:0] x,
                                      input logic right);
    if (right) return (x == 5'd20) ? 5'd0 : x + 5'd1;
    else       return (x == 5'd0) ? 5'd20 : x - 5'd1;
  endfunction

  state_t                   state_q, state_d;
  logic [2:0]               last_q;
  logic [2:0]               level_q;
  logic [4:0]               pend_q, pend_d;
  logic                     ovr_q, ovr_d;
  logic [COUNTER_WIDTH-1:0] cnt [5];
  logic [4:0]               car_x [10];

  logic [31:0] dec, base_per;
  logic [31:0] lim [5];
  logic [4:0]  tick;
  logic        grant;
  logic [2:0]  gnt_lane;
  logic [2:0]  rr_pick;
  logic        rr_hit;
  logic [3:0]  rr_idx;

  // Underflow of base - level*step clamps to the floor.
  always_comb begin
    dec = 32'(level_q) * c_PERIOD_STEP;
    if (dec >= c_BASE_PERIOD)
      base_per = c_MIN_PERIOD;
    else if (c_BASE_PERIOD - dec < c_MIN_PERIOD)
      base_per = c_MIN_PERIOD;
    else
      base_per = c_BASE_PERIOD - dec;
  end

  always_comb begin
    tick = '0;
    for (int k = 0; k < 5; k++) begin
      lim[k] = base_per + 32'(k) * c_LANE_SKEW - 32'd1;
      tick[k] = !i_Freeze && !i_Level_Up &&
                (32'(cnt[k]) >= lim[k]);
    end
  end

  always_comb begin
    rr_pick = last_q;
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int i = 1; i <= 5; i++) begin
      rr_idx = 4'(last_q) + 4'(i);
      if (rr_idx >= 4'd5) rr_idx = rr_idx - 4'd5;
      if (!rr_hit && pend_q[rr_idx[2:0]]) begin
        rr_hit = 1'b1;
        rr_pick = rr_idx[2:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant = 1'b0;
    gnt_lane = last_q;
    unique case (state_q)
      IDLE: begin
        if (rr_hit && !i_Freeze && !i_Level_Up) begin
          grant = 1'b1;
          gnt_lane = rr_pick;
          state_d = UPD_A;
        end
      end
      UPD_A:   state_d = UPD_B;
      UPD_B:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A grant clears first so a same-cycle tick re-arms without overrun.
  always_comb begin
    pend_d = pend_q;
    ovr_d = ovr_q;
    if (grant) pend_d[gnt_lane] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (tick[k]) begin
        if (pend_d[k]) ovr_d = 1'b1;
        pend_d[k] = 1'b1;
      end
    end
    if (i_Level_Up) pend_d = '0;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      last_q  <= 3'd4;
      level_q <= '0;
      pend_q  <= '0;
      ovr_q   <= 1'b0;
      for (int k = 0; k < 5; k++) cnt[k] <= '0;
      for (int i = 0; i < 10; i++) car_x[i] <= init_x(i);
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      if (grant) last_q <= gnt_lane;
      if (i_Level_Up && level_q != 3'd7) level_q <= level_q + 3'd1;
      for (int k = 0; k < 5; k++) begin
        if (i_Level_Up)
          cnt[k] <= '0;
        else if (!i_Freeze)
          cnt[k] <= tick[k] ? '0 : cnt[k] + COUNTER_WIDTH'(1);
      end
      if (state_q == UPD_A)
        car_x[car_a(last_q)] <= move(car_x[car_a(last_q)], ~last_q[0]);
      if (state_q == UPD_B)
        car_x[car_b(last_q)] <= move(car_x[car_b(last_q)], ~last_q[0]);
    end
  end

  for (genvar i = 0; i < 10; i++) begin : g_out
    assign o_Car_X[i*6 +: 6] = {1'b0, car_x[i]};
    assign o_Car_Y[i*6 +: 6] = car_y(i);
  end

  assign o_Level   = level_q;
  assign o_Busy    = (state_q != IDLE);
  assign o_Overrun = ovr_q;

endmodule

// File: doc/lane_sched.md
LANE_SCHED -- requirements
Module: lane_sched

Interface
REQ-001 SHALL have parameter c_BASE_PERIOD, default 700000, lane move period at level 0 (clock cycles).
REQ-002 SHALL have parameter c_PERIOD_STEP, default 100000, period decrease per level.
REQ-003 SHALL have parameter c_MIN_PERIOD, default 100000, period floor.
REQ-004 SHALL have parameter c_LANE_SKEW, default 50000, extra period per lane index k.
REQ-005 SHALL have parameter COUNTER_WIDTH, default 21, lane counter width; it must hold c_BASE_PERIOD + 4*c_LANE_SKEW.
REQ-006 SHALL have port i_Clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port i_Rst, input, 1, reset: synchronous, active-high.
REQ-008 SHALL have port i_Freeze, input, 1, high = hold all motion.
REQ-009 SHALL have port i_Level_Up, input, 1, single-cycle pulse that raises the level.
REQ-010 SHALL have port o_Car_X, output, 60, flattened car X positions, car i at bits [i*6 +: 6], upper bit 0.
REQ-011 SHALL have port o_Car_Y, output, 60, flattened car Y lanes, same packing.
REQ-012 SHALL have port o_Level, output, 3, current level 0..7.
REQ-013 SHALL have port o_Busy, output, 1, high while a lane update is in progress.
REQ-014 SHALL have port o_Overrun, output, 1, sticky flag: a lane tick hit an already-pending lane.

Function
REQ-015 SHALL use a fixed car table (car: lane k, Y, direction, initial X): 0:k0,12,R,0; 2:k0,12,R,6; 1:k1,11,L,20; 3:k1,11,L,14; 4:k2,10,R,3; 6:k2,10,R,9; 5:k3,9,L,4; 7:k3,9,L,18; 8:k4,8,R,4; 9:k4,8,R,11. For lane k, car A is the lower index and car B the higher.
REQ-016 SHALL drive o_Car_Y as constants from the table in all cycles, including during reset.
REQ-017 SHALL compute P = max(c_MIN_PERIOD, c_BASE_PERIOD - level*c_PERIOD_STEP); subtraction underflow clamps to c_MIN_PERIOD; lane k period P_k = P + k*c_LANE_SKEW.
REQ-018 SHALL keep one counter per lane; when not frozen, each counter increments every cycle; when counter >= P_k-1 it returns to 0 and the lane ticks.
REQ-019 SHALL, on a tick, set pending[k] on the same clock edge; if pending[k] is already set, it SHALL set o_Overrun instead, and pending stays at 1.
REQ-020 SHALL implement an FSM with states IDLE, UPD_A, UPD_B.
REQ-021 SHALL behave in IDLE as follows: if any pending bit is set and i_Freeze=0, grant one lane by round-robin, searching from (last granted+1) mod 5 upward; clear its pending bit; go to UPD_A.
REQ-022 SHALL, in UPD_A, write the new X of car A and go to UPD_B; in UPD_B, write car B and go to IDLE. Each write is visible on o_Car_X the next cycle.
REQ-023 SHALL move right-moving cars by X = (X==20) ? 0 : X+1, and left-moving cars by X = (X==0) ? 20 : X-1. X stays within 0..20.
REQ-024 SHALL give a fixed latency from a tick edge to car A update visible of 3 cycles when the lane is granted immediately; car B is visible 1 cycle later.
REQ-025 SHALL drive o_Busy high exactly in UPD_A and UPD_B.
REQ-026 SHALL, while i_Freeze=1, hold counters, issue no ticks, and make no grants; an UPD_A/UPD_B in progress completes; pending bits are retained.
REQ-027 SHALL, on i_Level_Up, saturate the level at 7, set all counters to 0, and clear all pending bits on the same edge; ticks in that cycle are discarded; an update in progress completes; positions are unchanged.
REQ-028 SHALL apply a tick and a grant of the same lane in the same cycle as grant clears, then tick sets, so pending ends at 1 with no overrun.

Reset
REQ-029 SHALL, when i_Rst=1 at a clock edge, set positions to the table initial X, level to 0, counters to 0, pending to 0, the round-robin pointer to lane 4 (so lane 0 is first), state to IDLE, and o_Busy and o_Overrun to 0; this overrides every other input, including mid-update.

Verification (small parameters: BASE=20, STEP=4, MIN=4, SKEW=2)
REQ-030 SHALL check: release reset -> car0 X 0->1 and car2 X 6->7 on consecutive cycles, 3 and 4 cycles after the first lane-0 tick (cycle 19); car1 unchanged until the lane-1 tick at cycle 21.
REQ-031 SHALL check wrap: run 21 lane-0 services -> car0 goes 20->0; 5 lane-3 services -> car5 goes 4,3,2,1,0,20.
REQ-032 SHALL check arbitration: SKEW=0 -> all lanes tick together; service order is lanes 0,1,2,3,4; o_Busy is high 10 of 15 cycles; each car moves exactly once; no overrun.
REQ-033 SHALL check freeze: assert i_Freeze for 100 cycles mid-count -> o_Car_X stable, no grants; on release the next tick arrives after the remaining count.
REQ-034 SHALL check level and overrun: 8 i_Level_Up pulses -> o_Level=7, lane-0 period 4; with SKEW=0, service takes 15 cycles, exceeding the 4-cycle period, so o_Overrun=1 and stays set until reset.
REQ-035 SHALL check reset mid-update: assert i_Rst in UPD_A -> next cycle all X equal the table values, o_Busy=0, o_Level=0, o_Overrun=0.
